fetch_bank_arbiter: RTL and testbench

Arbitrates the even/odd instruction-cache banks between the fetch read port and the refill write port, one decision per cycle. Fetch decodes its PC into a start bank (PC bit 4) and a first-instruction slot (PC bits 3:2) and needs one or both banks. A refill writes a 4-word block into one bank as a beat burst. Sits in fetch stage 1, between the PC/fill logic and the even/odd bank SRAMs.

---
 rtl/fetch_bank_arbiter.sv | 153 +++++++++++++++
 tb/tb_fetch_bank_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fetch_bank_arbiter.sv
// Even/odd I-cache bank arbiter between the fetch read port and the refill write port.
// One decision per cycle. Grants, enables and indices are combinational from the inputs and
// the registered state. A refill burst locks its bank until the last beat is accepted.
module fetch_bank_arbiter #(
  parameter int unsigned INDEX_W      = 6,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned SIZE_PC      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetchReq_i,
  input  logic [SIZE_PC-1:0] fetchPC_i,
  output logic               fetchGnt_o,
  input  logic               fillValid_i,
  input  logic               fillBank_i,
  input  logic [INDEX_W-1:0] fillIndex_i,
  input  logic               fillLast_i,
  output logic               fillReady_o,
  output logic               evenEn_o,
  output logic               oddEn_o,
  output logic               evenWe_o,
  output logic               oddWe_o,
  output logic [INDEX_W-1:0] evenIndex_o,
  output logic [INDEX_W-1:0] oddIndex_o,
  output logic [1:0]         fillWordOff_o
);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e       state_q, state_d;
  logic         lock_bank_q, lock_bank_d;
  logic [1:0]   beat_q, beat_d;
  logic [3:0]   starve_q, starve_d;

  logic               start_bank;
  logic [1:0]         first_slot;
  logic [INDEX_W-1:0] fetch_idx;
  logic [INDEX_W-1:0] fetch_even_idx;
  logic               need_even, need_odd;
  logic               fill_bank;
  logic               needs_fill_bank, needs_lock_bank;
  logic               conflict, fill_wins;
  logic               fetch_gnt, fill_rdy;

  // PC bits outside the bank/slot/index fields play no part in arbitration.
  logic unused_pc;
  assign unused_pc = ^{fetchPC_i[SIZE_PC-1:5+INDEX_W], fetchPC_i[1:0]};

  // Decode the fetch PC into bank needs and per-bank read indices.
  always_comb begin
    start_bank     = fetchPC_i[4];
    first_slot     = fetchPC_i[3:2];
    fetch_idx      = fetchPC_i[5+INDEX_W-1:5];
    need_even      = (first_slot != 2'd0) || !start_bank;
    need_odd       = (first_slot != 2'd0) || start_bank;
    // An odd start spills into the next set on the even bank, wrapping at the top.
    fetch_even_idx = start_bank ? fetch_idx + INDEX_W'(1) : fetch_idx;
  end

  // Arbitrate; reset forces every grant low.
  always_comb begin
    fill_bank       = (state_q == StBurst) ? lock_bank_q : fillBank_i;
    needs_fill_bank = fill_bank ? need_odd : need_even;
    needs_lock_bank = lock_bank_q ? need_odd : need_even;
    conflict        = fetchReq_i && fillValid_i && needs_fill_bank;
    fill_wins       = (starve_q == 4'(STARVE_LIMIT));
    fetch_gnt       = 1'b0;
    fill_rdy        = 1'b0;
    if (state_q == StIdle) begin
      fetch_gnt = fetchReq_i && !(conflict && fill_wins);
      fill_rdy  = fillValid_i && !(conflict && !fill_wins);
    end else begin
      // The locked bank belongs to the refill even on cycles with no beat.
      fetch_gnt = fetchReq_i && !needs_lock_bank;
      fill_rdy  = fillValid_i;
    end
    if (reset) begin
      fetch_gnt = 1'b0;
      fill_rdy  = 1'b0;
    end
  end

  // Drive the bank ports from whichever requesters were granted.
  always_comb begin
    evenEn_o      = 1'b0;
    oddEn_o       = 1'b0;
    evenWe_o      = 1'b0;
    oddWe_o       = 1'b0;
    evenIndex_o   = '0;
    oddIndex_o    = '0;
    fetchGnt_o    = fetch_gnt;
    fillReady_o   = fill_rdy;
    fillWordOff_o = reset ? 2'd0 : beat_q;
    if (fetch_gnt && need_even) begin
      evenEn_o    = 1'b1;
      evenIndex_o = fetch_even_idx;
    end
    if (fetch_gnt && need_odd) begin
      oddEn_o    = 1'b1;
      oddIndex_o = fetch_idx;
    end
    // Arbitration guarantees the fill bank is not also read by fetch here.
    if (fill_rdy && !fill_bank) begin
      evenEn_o    = 1'b1;
      evenWe_o    = 1'b1;
      evenIndex_o = fillIndex_i;
    end
    if (fill_rdy && fill_bank) begin
      oddEn_o    = 1'b1;
      oddWe_o    = 1'b1;
      oddIndex_o = fillIndex_i;
    end
  end

  // Next-state for the burst FSM, bank lock, beat and starvation counters.
  always_comb begin
    state_d     = state_q;
    lock_bank_d = lock_bank_q;
    beat_d      = beat_q;
    starve_d    = starve_q;
    if (fill_rdy) begin
      starve_d = 4'd0;
      if (fillLast_i) begin
        beat_d  = 2'd0;
        state_d = StIdle;
      end else begin
        beat_d = beat_q + 2'd1;
        if (state_q == StIdle) begin
          state_d     = StBurst;
          lock_bank_d = fillBank_i;
        end
      end
    end else if (fillValid_i && (starve_q < 4'(STARVE_LIMIT))) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      lock_bank_q <= 1'b0;
      beat_q      <= 2'd0;
      starve_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      lock_bank_q <= lock_bank_d;
      beat_q      <= beat_d;
      starve_q    <= starve_d;
    end
  end

endmodule

// File: tb/tb_fetch_bank_arbiter.sv
// Scoreboard bench for fetch_bank_arbiter: the stimulus pushes the hand-computed output vector
// for each driven cycle; a monitor pops and compares on the falling edge.
module tb_fetch_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetchReq_i;
  logic [31:0] fetchPC_i;
  logic        fetchGnt_o;
  logic        fillValid_i;
  logic        fillBank_i;
  logic [5:0]  fillIndex_i;
  logic        fillLast_i;
  logic        fillReady_o;
  logic        evenEn_o, oddEn_o, evenWe_o, oddWe_o;
  logic [5:0]  evenIndex_o, oddIndex_o;
  logic [1:0]  fillWordOff_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [19:0] v;
  } exp_t;

  exp_t sb_q[$];
  exp_t item;
  logic [19:0] act;

  fetch_bank_arbiter #(
    .INDEX_W     (6),
    .STARVE_LIMIT(8),
    .SIZE_PC     (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fetchReq_i   (fetchReq_i),
    .fetchPC_i    (fetchPC_i),
    .fetchGnt_o   (fetchGnt_o),
    .fillValid_i  (fillValid_i),
    .fillBank_i   (fillBank_i),
    .fillIndex_i  (fillIndex_i),
    .fillLast_i   (fillLast_i),
    .fillReady_o  (fillReady_o),
    .evenEn_o     (evenEn_o),
    .oddEn_o      (oddEn_o),
    .evenWe_o     (evenWe_o),
    .oddWe_o      (oddWe_o),
    .evenIndex_o  (evenIndex_o),
    .oddIndex_o   (oddIndex_o),
    .fillWordOff_o(fillWordOff_o)
  );

  always #5 clk = ~clk;

  // Output vector layout: {fetchGnt, fillReady, evenEn, evenWe, evenIndex, oddEn, oddWe,
  // oddIndex, fillWordOff}.
  function automatic logic [19:0] ev(input logic fg, input logic fr, input logic ee,
                                     input logic ew, input logic [5:0] ei, input logic oe,
                                     input logic ow, input logic [5:0] oi,
                                     input logic [1:0] wo);
    return {fg, fr, ee, ew, ei, oe, ow, oi, wo};
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue its expected outputs.
  task automatic step(input string name, input logic rst, input logic freq,
                      input logic [31:0] pc, input logic fv, input logic fb,
                      input logic [5:0] fidx, input logic fl, input logic [19:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    reset       = rst;
    fetchReq_i  = freq;
    fetchPC_i   = pc;
    fillValid_i = fv;
    fillBank_i  = fb;
    fillIndex_i = fidx;
    fillLast_i  = fl;
    x.name = name;
    x.v    = e;
    sb_q.push_back(x);
  endtask

  // Monitor: compare the outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      item = sb_q.pop_front();
      act  = {fetchGnt_o, fillReady_o, evenEn_o, evenWe_o, evenIndex_o,
              oddEn_o, oddWe_o, oddIndex_o, fillWordOff_o};
      checks++;
      if (act !== item.v) begin
        errors++;
        $display("FAIL %s: got %05h expected %05h", item.name, act, item.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    fetchReq_i  = 1'b1;
    fetchPC_i   = 32'h40;
    fillValid_i = 1'b1;
    fillBank_i  = 1'b1;
    fillIndex_i = 6'd5;
    fillLast_i  = 1'b1;

    step("reset_hold", 1, 1, 32'h40, 1, 1, 6'd5, 1, ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // No contention
    step("no_contention", 0, 1, 32'h40, 1, 1, 6'd5, 1, ev(1, 1, 1, 0, 2, 1, 1, 5, 0));
    step("index_wrap", 0, 1, 32'h7F4, 0, 0, 6'd0, 0, ev(1, 0, 1, 0, 0, 1, 0, 63, 0));
    step("fill_only", 0, 0, 32'h0, 1, 0, 6'd9, 1, ev(0, 1, 1, 1, 9, 0, 0, 0, 0));
    step("odd_fetch_even_fill", 0, 1, 32'h10, 1, 0, 6'd3, 1, ev(1, 1, 1, 1, 3, 1, 0, 0, 0));
    step("all_idle", 0, 0, 32'h0, 0, 0, 6'd0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Starvation: fill to bank 0 blocked 8 cycles, wins on the 9th.
    for (int i = 1; i <= 8; i++)
      step($sformatf("starve_wait%0d", i), 0, 1, 32'h04, 1, 0, 6'd7, 1,
           ev(1, 0, 1, 0, 0, 1, 0, 0, 0));
    step("starve_grant", 0, 1, 32'h04, 1, 0, 6'd7, 1, ev(0, 1, 1, 1, 7, 0, 0, 0, 0));
    step("starve_cleared", 0, 1, 32'h04, 1, 0, 6'd7, 1, ev(1, 0, 1, 0, 0, 1, 0, 0, 0));
    step("starve_drain", 0, 0, 32'h0, 1, 0, 6'd7, 1, ev(0, 1, 1, 1, 7, 0, 0, 0, 0));

    // Burst lock on bank 1
    step("burst_b0", 0, 1, 32'h00, 1, 1, 6'd10, 0, ev(1, 1, 1, 0, 0, 1, 1, 10, 0));
    step("burst_b1_lock", 0, 1, 32'h10, 1, 0, 6'd11, 0, ev(0, 1, 0, 0, 0, 1, 1, 11, 1));
    step("burst_b2_even", 0, 1, 32'h00, 1, 1, 6'd12, 0, ev(1, 1, 1, 0, 0, 1, 1, 12, 2));
    step("burst_b3_last", 0, 1, 32'h04, 1, 1, 6'd13, 1, ev(0, 1, 0, 0, 0, 1, 1, 13, 3));
    step("burst_after_idle", 0, 1, 32'h04, 0, 0, 6'd0, 0, ev(1, 0, 1, 0, 0, 1, 0, 0, 0));

    // Early last on beat 1
    step("early_b0", 0, 0, 32'h0, 1, 0, 6'd20, 0, ev(0, 1, 1, 1, 20, 0, 0, 0, 0));
    step("early_b1_last", 0, 0, 32'h0, 1, 0, 6'd21, 1, ev(0, 1, 1, 1, 21, 0, 0, 0, 1));
    step("early_idle_conflict", 0, 1, 32'h10, 1, 1, 6'd22, 0, ev(1, 0, 0, 0, 0, 1, 0, 0, 0));
    step("next_burst_b0", 0, 0, 32'h0, 1, 1, 6'd22, 0, ev(0, 1, 0, 0, 0, 1, 1, 22, 0));

    // Reset mid-burst
    step("pre_reset_b1", 0, 0, 32'h0, 1, 1, 6'd23, 0, ev(0, 1, 0, 0, 0, 1, 1, 23, 1));
    step("reset_async", 1, 1, 32'h04, 1, 1, 6'd24, 0, ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("reset_held", 1, 1, 32'h04, 1, 1, 6'd24, 0, ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("post_reset_idle", 0, 1, 32'h10, 1, 0, 6'd25, 1, ev(1, 1, 1, 1, 25, 1, 0, 0, 0));
    step("post_reset_starve0", 0, 1, 32'h04, 1, 0, 6'd26, 1, ev(1, 0, 1, 0, 0, 1, 0, 0, 0));

    // Let the monitor drain the queue within a bounded number of cycles.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
